// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS-subset control unit:
// opcodes, ALU operation classes, mux select codes, state encoding and the
// flattened control word that passes from the decoder to the top level.
package multicycle_control_pkg;

  localparam int OPC_WIDTH = 6;
  localparam int ST_WIDTH  = 4;

  // Supported instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // OpALU classes consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand selects
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State encoding; codes 13..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  // Control word produced by the decoder, one field per datapath control
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       irWrite;
    logic [1:0] pcSource;
    logic [1:0] opAlu;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic       regDst;
    logic       illegalOp;
    logic       instrDone;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // True for the opcodes this control unit knows how to sequence
  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Pure state-to-control-word decoder. Everything is a function of the
// current state, except the FETCH strobes (qualified by mem_ready), the
// MEM_WR completion pulse, and the illegal-opcode pulse in DECODE.
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic [5:0]        opcode_i,
  input  logic              mem_ready_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  state_t st;
  ctrl_t  ctrl;

  assign st     = state_t'(state_i);
  assign ctrl_o = ctrl;

  // Decode the control word; anything not set for a state stays 0
  always_comb begin
    ctrl = '0;
    case (st)
      S_FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.opAlu    = ALUOP_ADD;
        ctrl.pcSource = PCSRC_ALU;
        ctrl.irWrite  = mem_ready_i;
        ctrl.pcWrite  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl.aluSrcB   = SRCB_IMM_SH2;
        ctrl.opAlu     = ALUOP_ADD;
        ctrl.illegalOp = !is_supported_op(opcode_i);
        ctrl.instrDone = !is_supported_op(opcode_i);
      end
      S_MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.opAlu   = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memToReg  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.memWrite  = 1'b1;
        ctrl.iorD      = 1'b1;
        ctrl.instrDone = mem_ready_i;
      end
      S_R_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_RT;
        ctrl.opAlu   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_RT;
        ctrl.opAlu       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
        ctrl.instrDone   = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcWrite   = 1'b1;
        ctrl.pcSource  = PCSRC_JUMP;
        ctrl.instrDone = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.opAlu   = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset datapath. Holds the state
// register and next-state logic; the control word comes from control_decode.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPC_W = OPC_WIDTH,
  parameter int ST_W  = ST_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       OpALU,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [ST_W-1:0]  state
);

  state_t            state_q;
  state_t            state_d;
  logic [CTRL_W-1:0] ctrlBits;
  ctrl_t             ctrl;

  // Next-state selection; opcode only matters in DECODE and MEM_ADDR
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register; reset drops straight to IDLE, abandoning any instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  control_decode uDecode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrlBits)
  );

  assign ctrl        = ctrlBits;
  assign PCWrite     = ctrl.pcWrite;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD        = ctrl.iorD;
  assign MemRead     = ctrl.memRead;
  assign MemWrite    = ctrl.memWrite;
  assign MemtoReg    = ctrl.memToReg;
  assign IRWrite     = ctrl.irWrite;
  assign PCSource    = ctrl.pcSource;
  assign OpALU       = ctrl.opAlu;
  assign ALUSrcA     = ctrl.aluSrcA;
  assign ALUSrcB     = ctrl.aluSrcB;
  assign RegWrite    = ctrl.regWrite;
  assign RegDst      = ctrl.regDst;
  assign illegal_op  = ctrl.illegalOp;
  assign instr_done  = ctrl.instrDone;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step drives inputs, queues
// the expected state and control outputs for that cycle, then compares at
// the falling edge.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, OpALU, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, illegal_op, instr_done;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  // State codes as seen on the debug port
  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2,
    MEM_ADDR = 4'd3, MEM_RD = 4'd4, MEM_WB = 4'd5, MEM_WR = 4'd6,
    R_EXEC = 4'd7, R_WB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10,
    ADDI_EXEC = 4'd11, ADDI_WB = 4'd12;

  // Output bit positions in the observed vector
  localparam logic [17:0] B_DONE    = 18'h1 << 0;
  localparam logic [17:0] B_ILL     = 18'h1 << 1;
  localparam logic [17:0] B_REGDST  = 18'h1 << 2;
  localparam logic [17:0] B_REGWR   = 18'h1 << 3;
  localparam logic [17:0] B_SRCB01  = 18'h1 << 4;
  localparam logic [17:0] B_SRCB10  = 18'h2 << 4;
  localparam logic [17:0] B_SRCB11  = 18'h3 << 4;
  localparam logic [17:0] B_SRCA    = 18'h1 << 6;
  localparam logic [17:0] B_ALUSUB  = 18'h1 << 7;
  localparam logic [17:0] B_ALUFN   = 18'h2 << 7;
  localparam logic [17:0] B_PCS01   = 18'h1 << 9;
  localparam logic [17:0] B_PCS10   = 18'h2 << 9;
  localparam logic [17:0] B_IRWR    = 18'h1 << 11;
  localparam logic [17:0] B_MEM2REG = 18'h1 << 12;
  localparam logic [17:0] B_MEMWR   = 18'h1 << 13;
  localparam logic [17:0] B_MEMRD   = 18'h1 << 14;
  localparam logic [17:0] B_IORD    = 18'h1 << 15;
  localparam logic [17:0] B_PCWC    = 18'h1 << 16;
  localparam logic [17:0] B_PCW     = 18'h1 << 17;

  // Expected control words per state
  localparam logic [17:0] W_FETCH     = B_MEMRD | B_SRCB01 | B_IRWR | B_PCW;
  localparam logic [17:0] W_FETCH_ST  = B_MEMRD | B_SRCB01;
  localparam logic [17:0] W_DECODE    = B_SRCB11;
  localparam logic [17:0] W_DEC_ILL   = B_SRCB11 | B_ILL | B_DONE;
  localparam logic [17:0] W_R_EXEC    = B_SRCA | B_ALUFN;
  localparam logic [17:0] W_R_WB      = B_REGWR | B_REGDST | B_DONE;
  localparam logic [17:0] W_MEM_ADDR  = B_SRCA | B_SRCB10;
  localparam logic [17:0] W_MEM_RD    = B_MEMRD | B_IORD;
  localparam logic [17:0] W_MEM_WB    = B_REGWR | B_MEM2REG | B_DONE;
  localparam logic [17:0] W_MEM_WR_ST = B_MEMWR | B_IORD;
  localparam logic [17:0] W_MEM_WR    = B_MEMWR | B_IORD | B_DONE;
  localparam logic [17:0] W_BRANCH    = B_SRCA | B_ALUSUB | B_PCWC | B_PCS01 | B_DONE;
  localparam logic [17:0] W_JUMP      = B_PCW | B_PCS10 | B_DONE;
  localparam logic [17:0] W_ADDI_EXEC = B_SRCA | B_SRCB10;
  localparam logic [17:0] W_ADDI_WB   = B_REGWR | B_DONE;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [17:0] word;
  } exp_t;

  exp_t scoreboard[$];

  logic [17:0] observed;
  assign observed = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, PCSource, OpALU, ALUSrcA, ALUSrcB, RegWrite,
                     RegDst, illegal_op, instr_done};

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .PCSource    (PCSource),
    .OpALU       (OpALU),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .illegal_op  (illegal_op),
    .instr_done  (instr_done),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the inputs for this cycle and queue what the DUT should show
  task automatic applyStimulus(input string tag, input logic mr, input logic [5:0] op,
                               input logic [3:0] expSt, input logic [17:0] expWord);
    exp_t e;
    mem_ready = mr;
    opcode    = op;
    e.tag  = tag;
    e.st   = expSt;
    e.word = expWord;
    scoreboard.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the DUT at the falling edge
  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=empty expected=entry");
      return;
    end
    e = scoreboard.pop_front();
    checks++;
    assert (state === e.st) else begin
      errors++;
      $error("[TB] FAIL %s.state observed=%0d expected=%0d", e.tag, state, e.st);
    end
    checks++;
    assert (observed === e.word) else begin
      errors++;
      $error("[TB] FAIL %s.ctrl observed=%05h expected=%05h", e.tag, observed, e.word);
    end
    checks++;
    assert (!(MemRead === 1'b1 && MemWrite === 1'b1)) else begin
      errors++;
      $error("[TB] FAIL %s.rdwr_excl observed=%b%b expected=not11", e.tag, MemRead, MemWrite);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic mr, input logic [5:0] op,
                      input logic [3:0] expSt, input logic [17:0] expWord);
    applyStimulus(tag, mr, op, expSt, expWord);
    checkOutput();
  endtask

  // Watchdog so a stuck simulation still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Reset release: IDLE is all zeros, then FETCH with strobes
    step("idle",        1'b1, 6'h00, IDLE,  18'h0);
    step("fetch0",      1'b1, 6'h3F, FETCH, W_FETCH);

    // R-type: 4 cycles, opcode noise in non-sampling states ignored
    step("r_decode",    1'b1, 6'b000000, DECODE, W_DECODE);
    step("r_exec",      1'b1, 6'b000010, R_EXEC, W_R_EXEC);
    step("r_wb",        1'b1, 6'b101011, R_WB,   W_R_WB);

    // lw with FETCH stall once and two MEM_RD stall cycles
    step("lw_fetch_st", 1'b0, 6'h3F, FETCH,    W_FETCH_ST);
    step("lw_fetch",    1'b1, 6'h3F, FETCH,    W_FETCH);
    step("lw_decode",   1'b1, 6'b100011, DECODE,   W_DECODE);
    step("lw_addr",     1'b1, 6'b100011, MEM_ADDR, W_MEM_ADDR);
    step("lw_rd0",      1'b0, 6'b101011, MEM_RD,   W_MEM_RD);
    step("lw_rd1",      1'b0, 6'b000100, MEM_RD,   W_MEM_RD);
    step("lw_rd2",      1'b1, 6'b000000, MEM_RD,   W_MEM_RD);
    step("lw_wb",       1'b1, 6'h3F, MEM_WB,   W_MEM_WB);

    // beq then j
    step("beq_fetch",   1'b1, 6'h00, FETCH,  W_FETCH);
    step("beq_decode",  1'b1, 6'b000100, DECODE, W_DECODE);
    step("beq_exec",    1'b1, 6'h3F, BRANCH, W_BRANCH);
    step("j_fetch",     1'b1, 6'h00, FETCH,  W_FETCH);
    step("j_decode",    1'b1, 6'b000010, DECODE, W_DECODE);
    step("j_exec",      1'b1, 6'h3F, JUMP,   W_JUMP);

    // addi
    step("addi_fetch",  1'b1, 6'h00, FETCH,     W_FETCH);
    step("addi_decode", 1'b1, 6'b001000, DECODE,    W_DECODE);
    step("addi_exec",   1'b1, 6'h3F, ADDI_EXEC, W_ADDI_EXEC);
    step("addi_wb",     1'b1, 6'h3F, ADDI_WB,   W_ADDI_WB);

    // Illegal opcode: single-cycle pulse in DECODE, then FETCH
    step("ill_fetch",   1'b1, 6'h00, FETCH,  W_FETCH);
    step("ill_decode",  1'b1, 6'b111111, DECODE, W_DEC_ILL);
    step("ill_after",   1'b1, 6'b111111, FETCH,  W_FETCH);

    // sw with mem_ready high: 4 cycles
    step("sw_decode",   1'b1, 6'b101011, DECODE,   W_DECODE);
    step("sw_addr",     1'b1, 6'b101011, MEM_ADDR, W_MEM_ADDR);
    step("sw_wr",       1'b1, 6'h00, MEM_WR,   W_MEM_WR);

    // sw stalled in MEM_WR, then reset asserted between clock edges
    step("sw2_fetch",   1'b1, 6'h00, FETCH,    W_FETCH);
    step("sw2_decode",  1'b1, 6'b101011, DECODE,   W_DECODE);
    step("sw2_addr",    1'b1, 6'b101011, MEM_ADDR, W_MEM_ADDR);
    step("sw2_wr_st",   1'b0, 6'h00, MEM_WR,   W_MEM_WR_ST);
    @(negedge clk);
    checks++;
    assert (MemWrite === 1'b1) else begin
      errors++;
      $error("[TB] FAIL rst_pre_memwrite observed=%b expected=1", MemWrite);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (MemWrite === 1'b0) else begin
      errors++;
      $error("[TB] FAIL rst_async_memwrite observed=%b expected=0", MemWrite);
    end
    checks++;
    assert (state === IDLE) else begin
      errors++;
      $error("[TB] FAIL rst_async_state observed=%0d expected=%0d", state, IDLE);
    end
    checks++;
    assert (instr_done === 1'b0) else begin
      errors++;
      $error("[TB] FAIL rst_async_done observed=%b expected=0", instr_done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_idle",    1'b1, 6'h00, IDLE,  18'h0);
    step("rst_fetch",   1'b1, 6'h00, FETCH, W_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
